adc_xy_fb_addr: RTL and testbench

// Converts ADC X/Y sample pairs into framebuffer pixel writes for the XY-scope
// VGA path. Sits between the ADC sample capture (already in clk domain) and
// the SRAM framebuffer write port. Clips off-screen points, drops consecutive

---
 rtl/adc_xy_fb_addr_if.sv | 26 ++
 rtl/adc_xy_fb_addr.sv | 79 +++++++
 tb/tb_adc_xy_fb_addr.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/adc_xy_fb_addr_if.sv
// Sample-in / pixel-out stream bundle for the XY-scope framebuffer address stage.
// The master side produces samples and consumes pixel writes; the slave is the address stage.
interface adc_xy_fb_addr_if #(
  parameter int ADC_DATA_BITS  = 10,
  parameter int AXI_ADDR_WIDTH = 20,
  parameter int PIXEL_BITS     = 12
);
  logic                      s_valid;
  logic                      s_ready;
  logic [ADC_DATA_BITS-1:0]  s_x;
  logic [ADC_DATA_BITS-1:0]  s_y;
  logic                      m_valid;
  logic                      m_ready;
  logic [AXI_ADDR_WIDTH-1:0] m_addr;
  logic [PIXEL_BITS-1:0]     m_data;

  modport master (
    output s_valid, s_x, s_y, m_ready,
    input  s_ready, m_valid, m_addr, m_data
  );

  modport slave (
    input  s_valid, s_x, s_y, m_ready,
    output s_ready, m_valid, m_addr, m_data
  );
endinterface

// File: rtl/adc_xy_fb_addr.sv
// Turns ADC X/Y sample pairs into framebuffer pixel writes: clips off-screen points,
// drops repeats of the last plotted point, and forms y*H_VISIBLE+x over a 2-stage pipe.
module adc_xy_fb_addr #(
  parameter int                   ADC_DATA_BITS  = 10,
  parameter int                   H_VISIBLE      = 640,
  parameter int                   V_VISIBLE      = 480,
  parameter int                   AXI_ADDR_WIDTH = 20,
  parameter int                   PIXEL_BITS     = 12,
  parameter logic [PIXEL_BITS-1:0] PIXEL_COLOR   = 12'hFFF,
  parameter bit                   DEDUP          = 1'b1,
  parameter int                   CNT_BITS       = 16
) (
  input  logic                clk,
  input  logic                reset,
  adc_xy_fb_addr_if.slave     bus,
  output logic [CNT_BITS-1:0] clip_cnt,
  output logic [CNT_BITS-1:0] dup_cnt
);

  function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
    return (&v) ? v : v + CNT_BITS'(1);
  endfunction

  logic                      vld_p1, vld_p2, last_vld;
  logic [ADC_DATA_BITS-1:0]  x_p1, y_p1, last_x, last_y;
  logic [AXI_ADDR_WIDTH-1:0] addr_p2;
  logic [31:0]               addr_full_p1;
  logic                      adv_p2, s_ready_p0, accept_p0;
  logic                      clip_p0, dup_p0, keep_p0;

  // ---- stage 0: accept, clip, duplicate classification ----
  assign adv_p2     = !vld_p2 || bus.m_ready;
  assign s_ready_p0 = !vld_p1 || adv_p2;
  assign accept_p0  = bus.s_valid && s_ready_p0;

  // Clip wins over dedup so an off-screen point can never count as a repeat.
  assign clip_p0 = (32'(bus.s_x) >= 32'(H_VISIBLE)) || (32'(bus.s_y) >= 32'(V_VISIBLE));
  assign dup_p0  = !clip_p0 && DEDUP && last_vld &&
                   (bus.s_x == last_x) && (bus.s_y == last_y);
  assign keep_p0 = !clip_p0 && !dup_p0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1   <= 1'b0;
      vld_p2   <= 1'b0;
      last_vld <= 1'b0;
      addr_p2  <= '0;
      clip_cnt <= '0;
      dup_cnt  <= '0;
    end else begin
      if (s_ready_p0) vld_p1 <= accept_p0 && keep_p0;
      if (adv_p2) begin
        vld_p2 <= vld_p1;
        if (vld_p1) addr_p2 <= addr_full_p1[AXI_ADDR_WIDTH-1:0];
      end
      if (accept_p0 && keep_p0) last_vld <= 1'b1;
      if (accept_p0 && clip_p0) clip_cnt <= sat_inc(clip_cnt);
      if (accept_p0 && dup_p0)  dup_cnt  <= sat_inc(dup_cnt);
    end
  end

  always_ff @(posedge clk) begin
    if (accept_p0 && keep_p0) begin
      x_p1   <= bus.s_x;
      y_p1   <= bus.s_y;
      last_x <= bus.s_x;
      last_y <= bus.s_y;
    end
  end

  // ---- stage 1 -> stage 2: linear address ----
  assign addr_full_p1 = 32'(y_p1) * 32'(H_VISIBLE) + 32'(x_p1);

  assign bus.s_ready = s_ready_p0;
  assign bus.m_valid = vld_p2;
  assign bus.m_addr  = addr_p2;
  assign bus.m_data  = PIXEL_COLOR;

endmodule

// File: tb/tb_adc_xy_fb_addr.sv
// Directed bench for adc_xy_fb_addr: default instance (a), DEDUP=0 instance (b),
// CNT_BITS=4 instance (c), all fed the same sample stream.
module tb_adc_xy_fb_addr;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       s_valid = 1'b0;
  logic       m_ready = 1'b1;
  logic [9:0] s_x = '0;
  logic [9:0] s_y = '0;
  int         n_cmp = 0;
  int         n_err = 0;

  logic [15:0] clip_a, dup_a, clip_b, dup_b;
  logic [3:0]  clip_c, dup_c;

  always #5 clk = ~clk;

  adc_xy_fb_addr_if ifa ();
  adc_xy_fb_addr_if ifb ();
  adc_xy_fb_addr_if ifc ();

  assign ifa.s_valid = s_valid;  assign ifa.s_x = s_x;  assign ifa.s_y = s_y;  assign ifa.m_ready = m_ready;
  assign ifb.s_valid = s_valid;  assign ifb.s_x = s_x;  assign ifb.s_y = s_y;  assign ifb.m_ready = m_ready;
  assign ifc.s_valid = s_valid;  assign ifc.s_x = s_x;  assign ifc.s_y = s_y;  assign ifc.m_ready = m_ready;

  adc_xy_fb_addr dut_a (.clk(clk), .reset(reset), .bus(ifa.slave), .clip_cnt(clip_a), .dup_cnt(dup_a));
  adc_xy_fb_addr #(.DEDUP(1'b0)) dut_b (.clk(clk), .reset(reset), .bus(ifb.slave),
                                         .clip_cnt(clip_b), .dup_cnt(dup_b));
  adc_xy_fb_addr #(.CNT_BITS(4)) dut_c (.clk(clk), .reset(reset), .bus(ifc.slave),
                                        .clip_cnt(clip_c), .dup_cnt(dup_c));

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    bit         keep_a;
    bit         keep_b;
    int         addr;
    int         clip;
    int         dup;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Offer one sample for a single cycle; return at the negedge two clock edges after it was driven.
  task automatic send_one(input logic [9:0] x, input logic [9:0] y);
    @(negedge clk);
    s_valid = 1'b1; s_x = x; s_y = y;
    #1 chk("s_ready_on_offer", 32'(ifa.s_ready), 32'd1);
    @(negedge clk);
    s_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int sent, got;
    vecs[0]  = '{10'd3,    10'd2,    1'b1, 1'b1, 1283,   0, 0};
    vecs[1]  = '{10'd640,  10'd0,    1'b0, 1'b0, 0,      1, 0};
    vecs[2]  = '{10'd639,  10'd479,  1'b1, 1'b1, 307199, 1, 0};
    vecs[3]  = '{10'd5,    10'd5,    1'b1, 1'b1, 3205,   1, 0};
    vecs[4]  = '{10'd5,    10'd5,    1'b0, 1'b1, 3205,   1, 1};
    vecs[5]  = '{10'd6,    10'd5,    1'b1, 1'b1, 3206,   1, 1};
    vecs[6]  = '{10'd5,    10'd5,    1'b1, 1'b1, 3205,   1, 1};
    vecs[7]  = '{10'd0,    10'd480,  1'b0, 1'b0, 0,      2, 1};
    vecs[8]  = '{10'd0,    10'd0,    1'b1, 1'b1, 0,      2, 1};
    vecs[9]  = '{10'd0,    10'd0,    1'b0, 1'b1, 0,      2, 2};
    vecs[10] = '{10'd1023, 10'd1023, 1'b0, 1'b0, 0,      3, 2};

    // Reset state
    #2 reset = 1'b1;
    #1;
    chk("rst_m_valid", 32'(ifa.m_valid), 32'd0);
    chk("rst_m_addr",  32'(ifa.m_addr),  32'd0);
    chk("rst_m_data",  32'(ifa.m_data),  32'hFFF);
    chk("rst_clip",    32'(clip_a),      32'd0);
    chk("rst_dup",     32'(dup_a),       32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1 chk("rst_s_ready", 32'(ifa.s_ready), 32'd1);

    // Table: clip, dedup, address, DEDUP=0 variant
    for (int i = 0; i < 11; i++) begin
      send_one(vecs[i].x, vecs[i].y);
      chk($sformatf("v%0d_valid_a", i), 32'(ifa.m_valid), 32'(vecs[i].keep_a));
      if (vecs[i].keep_a) chk($sformatf("v%0d_addr_a", i), 32'(ifa.m_addr), vecs[i].addr);
      chk($sformatf("v%0d_valid_b", i), 32'(ifb.m_valid), 32'(vecs[i].keep_b));
      if (vecs[i].keep_b) chk($sformatf("v%0d_addr_b", i), 32'(ifb.m_addr), vecs[i].addr);
      chk($sformatf("v%0d_clip_a", i), 32'(clip_a), vecs[i].clip);
      chk($sformatf("v%0d_dup_a", i),  32'(dup_a),  vecs[i].dup);
      chk($sformatf("v%0d_dup_b", i),  32'(dup_b),  32'd0);
      chk($sformatf("v%0d_clip_c", i), 32'(clip_c), vecs[i].clip);
    end
    chk("m_data_const", 32'(ifa.m_data), 32'hFFF);

    // Backpressure: 10 stalled cycles, then drain
    @(negedge clk);
    m_ready = 1'b0;
    sent = 0;
    for (int c = 0; c < 10; c++) begin
      if (c != 0) @(negedge clk);
      s_valid = (sent < 5); s_x = 10'(10 + sent); s_y = 10'd1;
      #1 if (s_valid && ifa.s_ready) sent++;
    end
    @(negedge clk);
    #1;
    chk("bp_held", 32'(sent), 32'd2);
    chk("bp_s_ready_low", 32'(ifa.s_ready), 32'd0);
    chk("bp_m_valid_held", 32'(ifa.m_valid), 32'd1);
    chk("bp_m_addr_held", 32'(ifa.m_addr), 32'd650);
    m_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 30 && got < 5; c++) begin
      if (c != 0) @(negedge clk);
      s_valid = (sent < 5); s_x = 10'(10 + sent); s_y = 10'd1;
      #1;
      if (ifa.m_valid) begin
        chk($sformatf("bp_addr%0d", got), 32'(ifa.m_addr), 32'(650 + got));
        got++;
      end
      if (s_valid && ifa.s_ready) sent++;
    end
    s_valid = 1'b0;
    chk("bp_count", 32'(got), 32'd5);
    repeat (2) @(negedge clk);
    chk("bp_no_repeat", 32'(ifa.m_valid), 32'd0);

    // Reset mid-stream with a held output
    m_ready = 1'b0;
    send_one(10'd20, 10'd3);
    chk("mid_pre_valid", 32'(ifa.m_valid), 32'd1);
    chk("mid_pre_clip", 32'(clip_a), 32'd3);
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(ifa.m_valid), 32'd0);
    chk("mid_rst_clip", 32'(clip_a), 32'd0);
    chk("mid_rst_dup", 32'(dup_a), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    m_ready = 1'b1;
    send_one(10'd20, 10'd3);
    chk("mid_repeat_valid", 32'(ifa.m_valid), 32'd1);
    chk("mid_repeat_addr", 32'(ifa.m_addr), 32'd1940);
    chk("mid_repeat_dup", 32'(dup_a), 32'd0);

    // Counter saturation: 20 back-to-back clipped samples
    @(negedge clk);
    s_valid = 1'b1; s_x = 10'd700; s_y = 10'd0;
    repeat (20) @(negedge clk);
    s_valid = 1'b0;
    #1;
    chk("sat_clip_a", 32'(clip_a), 32'd20);
    chk("sat_clip_c", 32'(clip_c), 32'd15);
    chk("sat_no_write", 32'(ifa.m_valid), 32'd0);
    repeat (2) @(negedge clk);
    chk("sat_clip_c_hold", 32'(clip_c), 32'd15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
